// File: rtl/gpi_pkg.sv
// gpi_pkg: register map and width constants shared by the GPI event block
package gpi_pkg;
    localparam int PERIOD_W = 16;
    localparam logic [4:0] REG_DATA   = 5'd0;
    localparam logic [4:0] REG_EVENT  = 5'd1;
    localparam logic [4:0] REG_RISE   = 5'd2;
    localparam logic [4:0] REG_FALL   = 5'd3;
    localparam logic [4:0] REG_PERIOD = 5'd4;
endpackage

// File: rtl/gpi_debounce_bit.sv
// gpi_debounce_bit: one input pin through sync2, stability counter and debounced flop
module gpi_debounce_bit
    import gpi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic tick,
    output logic deb,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;
    logic [1:0] cnt;
    logic       flip;
    // the debounced value flips when a tick finds the input still different after three stable ticks
    assign flip = tick && (sync[1] != deb) && (cnt == 2'd3);
    assign rise = flip && sync[1];
    assign fall = flip && !sync[1];
    // synchronize, count stable ticks, and update the debounced value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            cnt  <= (sync[1] == deb || flip) ? 2'd0 : tick ? cnt + 2'd1 : cnt;
            if (flip) deb <= sync[1];
        end
    end
endmodule

// File: rtl/gpi_event.sv
// gpi_event: debounced general-purpose inputs with edge events and level interrupt
module gpi_event
    import gpi_pkg::*;
#(
    parameter int                  W          = 8,
    parameter logic [PERIOD_W-1:0] DB_DEFAULT = 16'd999
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] din,
    output logic         irq
);
    logic [W-1:0]        deb, rise, fall, evt, rise_en, fall_en, clr;
    logic [PERIOD_W-1:0] period, pcnt;
    logic                tick, we, unused_ok;
    assign we        = cs && write;
    assign tick      = (pcnt == period);
    assign clr       = (we && addr == REG_EVENT) ? wr_data[W-1:0] : '0;
    assign irq       = |evt;
    assign unused_ok = ^{read, wr_data};
    for (genvar i = 0; i < W; i++) begin : g_bit
        gpi_debounce_bit u_bit (
            .clk   (clk),
            .reset (reset),
            .din   (din[i]),
            .tick  (tick),
            .deb   (deb[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end
    // prescaler wraps after PERIOD and restarts on any period write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pcnt <= '0;
        else        pcnt <= ((we && addr == REG_PERIOD) || tick) ? '0 : pcnt + 1'b1;
    end
    // register file; a new edge event wins over a same-cycle write-1-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt     <= '0;
            rise_en <= '0;
            fall_en <= '0;
            period  <= DB_DEFAULT;
        end else begin
            evt <= (evt & ~clr) | (rise & rise_en) | (fall & fall_en);
            if (we && addr == REG_RISE)   rise_en <= wr_data[W-1:0];
            if (we && addr == REG_FALL)   fall_en <= wr_data[W-1:0];
            if (we && addr == REG_PERIOD) period  <= wr_data[PERIOD_W-1:0];
        end
    end
    // read mux, zero-extended, independent of cs/read
    always_comb begin
        rd_data = '0;
        case (addr)
            REG_DATA:   rd_data[W-1:0]        = deb;
            REG_EVENT:  rd_data[W-1:0]        = evt;
            REG_RISE:   rd_data[W-1:0]        = rise_en;
            REG_FALL:   rd_data[W-1:0]        = fall_en;
            REG_PERIOD: rd_data[PERIOD_W-1:0] = period;
            default:    rd_data               = '0;
        endcase
    end
endmodule

// File: tb/tb_gpi_event.sv
// tb_gpi_event: directed checks of debounce timing, events, irq and register map
module tb_gpi_event;
    logic        clk = 1'b0, reset = 1'b0, cs = 1'b0, read = 1'b0, write = 1'b0, irq;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0, rd_data;
    logic [7:0]  din = '0;
    int          n_cmp = 0, n_err = 0;

    gpi_event #(.W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #12;
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_deb", 5'd0, 32'd0);
        rd_chk("rst_evt", 5'd1, 32'd0);
        rd_chk("rst_rise", 5'd2, 32'd0);
        rd_chk("rst_fall", 5'd3, 32'd0);
        rd_chk("rst_period", 5'd4, 32'd999);
        @(negedge clk) reset = 1'b1;
        wr(5'd2, 32'h07);
        wr(5'd4, 32'd0);
        rd_chk("rise_en_rb", 5'd2, 32'h07);
        rd_chk("period0_rb", 5'd4, 32'd0);
        din[0] = 1'b1;
        cyc(5);
        rd_chk("deb0_edge5", 5'd0, 32'h00);
        check("irq_edge5", {31'd0, irq}, 32'd0);
        cyc(1);
        rd_chk("deb0_edge6", 5'd0, 32'h01);
        rd_chk("evt0_edge6", 5'd1, 32'h01);
        check("irq_edge6", {31'd0, irq}, 32'd1);
        din[1] = 1'b1;
        cyc(3);
        din[1] = 1'b0;
        cyc(8);
        rd_chk("glitch_deb", 5'd0, 32'h01);
        rd_chk("glitch_evt", 5'd1, 32'h01);
        wr(5'd1, 32'h01);
        rd_chk("w1c_evt", 5'd1, 32'h00);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        wr(5'd0, 32'hff);
        rd_chk("deb_ro", 5'd0, 32'h01);
        wr(5'd5, 32'hffff_ffff);
        rd_chk("addr5_zero", 5'd5, 32'h0);
        rd_chk("addr31_zero", 5'd31, 32'h0);
        wr(5'd4, 32'd9);
        din[2] = 1'b1;
        cyc(39);
        rd_chk("p9_edge39", 5'd0, 32'h01);
        cyc(1);
        rd_chk("p9_edge40", 5'd0, 32'h05);
        rd_chk("p9_evt", 5'd1, 32'h04);
        rd_chk("period9_rb", 5'd4, 32'd9);
        wr(5'd4, 32'd0);
        wr(5'd3, 32'h09);
        din[0] = 1'b0;
        cyc(8);
        rd_chk("fall0_deb", 5'd0, 32'h04);
        rd_chk("pend05_evt", 5'd1, 32'h05);
        wr(5'd1, 32'h01);
        rd_chk("clr1_evt", 5'd1, 32'h04);
        check("clr1_irq", {31'd0, irq}, 32'd1);
        wr(5'd1, 32'h04);
        rd_chk("clr4_evt", 5'd1, 32'h00);
        check("clr4_irq", {31'd0, irq}, 32'd0);
        din[3] = 1'b1;
        cyc(8);
        rd_chk("rise3_deb", 5'd0, 32'h0c);
        rd_chk("rise3_noevt", 5'd1, 32'h00);
        din[3] = 1'b0;
        cyc(5);
        cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'h08;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
        rd_chk("setwin_deb", 5'd0, 32'h04);
        rd_chk("setwin_evt", 5'd1, 32'h08);
        wr(5'd3, 32'h00);
        rd_chk("en_clr_evt", 5'd1, 32'h08);
        rd_chk("fall_en_rb", 5'd3, 32'h00);
        check("en_clr_irq", {31'd0, irq}, 32'd1);
        wr(5'd1, 32'h08);
        rd_chk("final_clr", 5'd1, 32'h00);
        din[4] = 1'b1;
        cyc(4);
        #2 reset = 1'b0;
        #1;
        check("arst_irq", {31'd0, irq}, 32'd0);
        rd_chk("arst_deb", 5'd0, 32'd0);
        rd_chk("arst_rise", 5'd2, 32'd0);
        rd_chk("arst_period", 5'd4, 32'd999);
        @(negedge clk) reset = 1'b1;
        cyc(3999);
        rd_chk("post_rst_early", 5'd0, 32'h00);
        cyc(1);
        rd_chk("post_rst_deb", 5'd0, 32'h14);
        rd_chk("post_rst_evt", 5'd1, 32'h00);
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
